// File: rtl/arb_cal_pkg.sv
// Shared types and constants for the arbiter-driven delay-trim calibrator.
package arb_cal_pkg;

  localparam int WIN_LOG2_W = 3;
  localparam int SETTLE_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    DECIDE,
    FINISH
  } arb_cal_state_e;

  // HOLD doubles as "no previous step yet" for reversal tracking.
  typedef enum logic [1:0] {
    HOLD,
    UP,
    DN
  } arb_cal_dir_e;

endpackage

// File: rtl/arb_sync2.sv
// Two-flop synchronizer for the arbiter decision when it is not clk-registered.
module arb_sync2 (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/arb_phase_cal.sv
// Majority-vote trim-code calibrator: settle, accumulate arbiter votes, step code, stop on
// REV_MAX direction reversals or max_iter. Define ARB_CAL_SYNC_EN to synchronize arb_out.
module arb_phase_cal
  import arb_cal_pkg::*;
#(
  parameter int CODE_W  = 6,
  parameter int REV_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  arb_out,
  input  logic                  start,
  input  logic [CODE_W-1:0]     init_code,
  input  logic [WIN_LOG2_W-1:0] win_log2,
  input  logic [SETTLE_W-1:0]   settle_cyc,
  input  logic [7:0]            max_iter,
  output logic [CODE_W-1:0]     code,
  output logic                  busy,
  output logic                  done,
  output logic                  lock,
  output logic [2:0]            state_dbg
);

  localparam int REV_W = $clog2(REV_MAX + 1);
  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  arb_cal_state_e        state_q, state_d;
  arb_cal_dir_e          last_dir_q, last_dir_d;
  arb_cal_dir_e          step;
  logic [CODE_W-1:0]     code_q, code_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  lock_q, lock_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [8:0]            ones_q, ones_d;
  logic [REV_W-1:0]      rev_q, rev_d, rev_nxt;
  logic [7:0]            iter_q, iter_d, iter_nxt;
  logic [WIN_LOG2_W-1:0] win_q, win_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [7:0]            max_iter_q, max_iter_d;
  logic [8:0]            win_n;
  logic                  up_req, dn_req, rev_inc, lock_nxt, finish;
  logic                  arb_s;

`ifdef ARB_CAL_SYNC_EN
  arb_sync2 u_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (arb_out),
    .q    (arb_s)
  );
`else
  assign arb_s = arb_out;
`endif

  // Protocol: start is a one-cycle request honoured only in IDLE; busy rises the next
  // cycle and falls in the same cycle done pulses, so busy && done never overlap.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    code_d     = code_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    rev_d      = rev_q;
    iter_d     = iter_q;
    win_d      = win_q;
    settle_d   = settle_q;
    max_iter_d = max_iter_q;

    win_n  = 9'd1 << win_q;
    up_req = {ones_q, 1'b0} > {1'b0, win_n};
    dn_req = {ones_q, 1'b0} < {1'b0, win_n};
    step   = HOLD;
    if (up_req && (code_q != CODE_MAX)) begin
      step = UP;
    end else if (dn_req && (code_q != '0)) begin
      step = DN;
    end
    rev_inc  = (step != HOLD) && (last_dir_q != HOLD) && (step != last_dir_q);
    rev_nxt  = rev_q + REV_W'(rev_inc);
    iter_nxt = iter_q + 8'd1;
    lock_nxt = (rev_nxt >= REV_W'(REV_MAX));
    finish   = lock_nxt || ((max_iter_q != 8'd0) && (iter_nxt == max_iter_q));

    case (state_q)
      IDLE: begin
        if (start) begin
          code_d     = init_code;
          lock_d     = 1'b0;
          ones_d     = '0;
          rev_d      = '0;
          iter_d     = '0;
          cnt_d      = '0;
          last_dir_d = HOLD;
          win_d      = win_log2;
          settle_d   = settle_cyc;
          max_iter_d = max_iter;
          busy_d     = 1'b1;
          state_d    = (settle_cyc == '0) ? ACCUM : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == (8'(settle_q) - 8'd1)) begin
          cnt_d   = '0;
          state_d = ACCUM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACCUM: begin
        ones_d = ones_q + 9'(arb_s);
        if ({1'b0, cnt_q} == (win_n - 9'd1)) begin
          cnt_d   = '0;
          state_d = DECIDE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DECIDE: begin
        if (step == UP) begin
          code_d = code_q + CODE_W'(1);
        end else if (step == DN) begin
          code_d = code_q - CODE_W'(1);
        end
        if (step != HOLD) begin
          last_dir_d = step;
        end
        rev_d  = rev_nxt;
        iter_d = iter_nxt;
        ones_d = '0;
        if (lock_nxt) begin
          lock_d = 1'b1;
        end
        if (finish) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = (settle_q == '0) ? ACCUM : SETTLE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      last_dir_q <= HOLD;
      code_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      ones_q     <= '0;
      rev_q      <= '0;
      iter_q     <= '0;
      win_q      <= '0;
      settle_q   <= '0;
      max_iter_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      code_q     <= code_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      rev_q      <= rev_d;
      iter_q     <= iter_d;
      win_q      <= win_d;
      settle_q   <= settle_d;
      max_iter_q <= max_iter_d;
    end
  end

  assign code      = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lock      = lock_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_arb_phase_cal.sv
// Scoreboard bench for arb_phase_cal: a plant model drives arb_out from the trim code.
module tb_arb_phase_cal;
  import arb_cal_pkg::*;

  localparam int CODE_W  = 6;
  localparam int REV_MAX = 4;
  localparam int CMAX    = (1 << CODE_W) - 1;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              arb_out = 1'b0;
  logic              start = 1'b0;
  logic [CODE_W-1:0] init_code = '0;
  logic [2:0]        win_log2 = '0;
  logic [3:0]        settle_cyc = '0;
  logic [7:0]        max_iter = '0;
  logic [CODE_W-1:0] code;
  logic              busy, done, lock;
  logic [2:0]        state_dbg;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // plant: 0 const 1, 1 threshold crossing, 3 alternating, 4 const 0
  int mode = 0;
  int thr  = 0;

  logic [CODE_W-1:0] exp_q[$];
  int                exp_code, exp_iters, exp_lock;
  int                dec_cnt  = 0;
  int                done_cnt = 0;
  arb_cal_state_e    prev_st  = IDLE;

  arb_phase_cal #(.CODE_W(CODE_W), .REV_MAX(REV_MAX)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .arb_out    (arb_out),
    .start      (start),
    .init_code  (init_code),
    .win_log2   (win_log2),
    .settle_cyc (settle_cyc),
    .max_iter   (max_iter),
    .code       (code),
    .busy       (busy),
    .done       (done),
    .lock       (lock),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    case (mode)
      0:       arb_out = 1'b1;
      1:       arb_out = (int'(code) <= thr);
      3:       arb_out = ~arb_out;
      default: arb_out = 1'b0;
    endcase
  end

  // Reference algorithm: majority vote, saturating step, reversal counting.
  task automatic model_run(input int init, input int win, input int maxit);
    int c, n, ones, dir, last, rev, it, lk;
    c = init; n = 1 << win; last = 0; rev = 0; it = 0; lk = 0;
    exp_q.delete();
    while (it < 1000) begin
      case (mode)
        0:       ones = n;
        1:       ones = (c <= thr) ? n : 0;
        3:       ones = n / 2;
        default: ones = 0;
      endcase
      dir = 0;
      if (2 * ones > n && c != CMAX) dir = 1;
      else if (2 * ones < n && c != 0) dir = -1;
      if (dir != 0) begin
        if (last != 0 && dir != last) rev++;
        last = dir;
        c = c + dir;
      end
      it++;
      exp_q.push_back(CODE_W'(c));
      if (rev >= REV_MAX) begin
        lk = 1;
        break;
      end
      if (maxit != 0 && it == maxit) break;
    end
    exp_code = c; exp_iters = it; exp_lock = lk;
  endtask

  always @(negedge clk) begin
    if (!rstb) begin
      prev_st = IDLE;
    end else begin
      if (prev_st == DECIDE) begin
        logic [31:0] e;
        dec_cnt++;
        e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
        check("step_code", 32'(code), e);
      end
      if (done) begin
        done_cnt++;
        check("done_sb_empty", exp_q.size(), 0);
        check("done_iters", dec_cnt, exp_iters);
        check("done_lock", 32'(lock), exp_lock);
        check("done_busy_low", 32'(busy), 0);
      end
      prev_st = arb_cal_state_e'(state_dbg);
    end
  end

  task automatic run_cal(input int init, input int win, input int settle, input int maxit,
                         input int md, input int th, input bit poke);
    int d0, n;
    mode = md; thr = th;
    model_run(init, win, maxit);
    @(negedge clk);
    init_code = CODE_W'(init); win_log2 = 3'(win); settle_cyc = 4'(settle);
    max_iter = 8'(maxit); start = 1'b1; dec_cnt = 0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    if (poke) begin
      repeat (6) @(negedge clk);
      init_code = '0; win_log2 = 3'd7; settle_cyc = 4'd15; max_iter = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_during_poke", 32'(busy), 1);
    end
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", 32'(n < 20000), 1);
    repeat (4) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("idle_code_hold", 32'(code), exp_code);
    check("idle_lock_hold", 32'(lock), exp_lock);
    check("idle_busy", 32'(busy), 0);
    check("idle_state", 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_code", 32'(code), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_lock", 32'(lock), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    run_cal(10, 2, 1, 5, 0, 0, 1'b0);   // steady up-steps 11..15
    run_cal(17, 1, 0, 0, 1, 20, 1'b0);  // dither 20/21 until lock
    run_cal(17, 1, 0, 8, 1, 20, 1'b0);  // lock on the last allowed iteration
    run_cal(63, 2, 2, 3, 0, 0, 1'b0);   // top saturation
    run_cal(2, 1, 1, 4, 4, 0, 1'b0);    // bottom saturation
    run_cal(30, 3, 2, 4, 3, 0, 1'b0);   // exact half votes hold
    run_cal(40, 0, 3, 0, 1, 35, 1'b0);  // descend then lock
    run_cal(10, 2, 1, 5, 0, 0, 1'b1);   // start and input changes mid-run ignored
    for (int i = 0; i < 4; i++) begin
      run_cal($urandom_range(0, CMAX), $urandom_range(0, 4), $urandom_range(0, 6),
              ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 20), 1,
              $urandom_range(5, 58), 1'b0);
    end

    // asynchronous reset in the middle of a long accumulation window
    mode = 0;
    @(negedge clk);
    init_code = 6'd10; win_log2 = 3'd7; settle_cyc = 4'd3; max_iter = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (state_dbg != 3'(ACCUM) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_accum", 32'(state_dbg), 32'(ACCUM));
    repeat (20) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check("mid_rst_code", 32'(code), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    check("mid_rst_lock", 32'(lock), 0);
    exp_q.delete();
    @(negedge clk);
    rstb = 1'b1;
    run_cal(10, 2, 0, 5, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
